// File: rtl/i2c_rx_deserializer_if.sv
// Word-out stream of the I2C receive deserializer: head-of-buffer word with valid/ready.
interface i2c_rx_deserializer_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/i2c_rx_deserializer.sv
// Serial-to-parallel receive deserializer: packs qualified bits into DATA_W-bit words.
// Latency: out_valid rises on the edge that accepts the last bit of a word (empty buffer).
// Backpressure: 2-entry buffer absorbs one word of stall; a word completing into a full buffer is dropped and flags sticky overflow.
module i2c_rx_deserializer #(
    parameter int DATA_W    = 8,
    parameter int MSB_FIRST = 1,
    parameter int CNT_W     = $clog2(DATA_W + 1)
) (
    input  logic                    i2c_clk,
    input  logic                    rst_n,
    input  logic                    bit_in,
    input  logic                    bit_en,
    input  logic                    frame_clr,
    output logic [CNT_W-1:0]        bit_cnt,
    output logic                    overflow,
    input  logic                    ovf_clr,
    i2c_rx_deserializer_if.master   out_if
);

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

    buf_state_t        buf_state_q, buf_state_d;
    logic [DATA_W-1:0] sr_q;
    logic [DATA_W-1:0] sr_shift;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] pend_q, pend_d;
    logic              accept;
    logic              word_done;
    logic              pop;
    logic              ovf_set;

    // frame_clr wins over bit_en: the bit offered during a START is discarded.
    assign accept    = bit_en & ~frame_clr;
    assign sr_shift  = (MSB_FIRST != 0) ? {sr_q[DATA_W-2:0], bit_in}
                                        : {bit_in, sr_q[DATA_W-1:1]};
    assign word_done = accept && (cnt_q == CNT_W'(DATA_W - 1));

    always_ff @(posedge i2c_clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (frame_clr) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            if (word_done) begin
                sr_q  <= '0;
                cnt_q <= '0;
            end else begin
                sr_q  <= sr_shift;
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign out_if.out_valid = (buf_state_q != BUF_EMPTY);
    assign out_if.out_data  = head_q;
    assign bit_cnt          = cnt_q;
    assign pop              = out_if.out_valid & out_if.out_ready;

    always_ff @(posedge i2c_clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_state_q <= BUF_EMPTY;
            head_q      <= '0;
            pend_q      <= '0;
        end else begin
            buf_state_q <= buf_state_d;
            head_q      <= head_d;
            pend_q      <= pend_d;
        end
    end

    always_comb begin
        buf_state_d = buf_state_q;
        head_d      = head_q;
        pend_d      = pend_q;
        ovf_set     = 1'b0;
        case (buf_state_q)
            BUF_EMPTY: begin
                if (word_done) begin
                    head_d      = sr_shift;
                    buf_state_d = BUF_ONE;
                end
            end
            BUF_ONE: begin
                case ({word_done, pop})
                    2'b10: begin
                        pend_d      = sr_shift;
                        buf_state_d = BUF_FULL;
                    end
                    2'b11: head_d = sr_shift;
                    2'b01: buf_state_d = BUF_EMPTY;
                    default: ;
                endcase
            end
            BUF_FULL: begin
                case ({word_done, pop})
                    2'b11: begin
                        head_d = pend_q;
                        pend_d = sr_shift;
                    end
                    2'b10: ovf_set = 1'b1;
                    2'b01: begin
                        head_d      = pend_q;
                        buf_state_d = BUF_ONE;
                    end
                    default: ;
                endcase
            end
            default: buf_state_d = BUF_EMPTY;
        endcase
    end

    // A drop in the same cycle as a clear must stay visible.
    always_ff @(posedge i2c_clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2c_rx_deserializer.sv
// Directed bench: MSB-first instance carries most scenarios, an LSB-first instance checks bit order.
module tb_i2c_rx_deserializer;

    logic       i2c_clk = 1'b0;
    logic       rst_n;
    logic       bit_in;
    logic       bit_en;
    logic       frame_clr;
    logic       ovf_clr;
    logic [3:0] bit_cnt;
    logic       overflow;

    logic       bit_en_l;
    logic       frame_clr_l;
    logic       ovf_clr_l;
    logic [3:0] bit_cnt_l;
    logic       overflow_l;

    int tests = 0;
    int fails = 0;

    always #5 i2c_clk = ~i2c_clk;

    i2c_rx_deserializer_if #(.DATA_W(8)) m_if ();
    i2c_rx_deserializer_if #(.DATA_W(8)) l_if ();

    i2c_rx_deserializer #(.DATA_W(8), .MSB_FIRST(1)) u_msb (
        .i2c_clk   (i2c_clk),
        .rst_n     (rst_n),
        .bit_in    (bit_in),
        .bit_en    (bit_en),
        .frame_clr (frame_clr),
        .bit_cnt   (bit_cnt),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr),
        .out_if    (m_if.master)
    );

    i2c_rx_deserializer #(.DATA_W(8), .MSB_FIRST(0)) u_lsb (
        .i2c_clk   (i2c_clk),
        .rst_n     (rst_n),
        .bit_in    (bit_in),
        .bit_en    (bit_en_l),
        .frame_clr (frame_clr_l),
        .bit_cnt   (bit_cnt_l),
        .overflow  (overflow_l),
        .ovf_clr   (ovf_clr_l),
        .out_if    (l_if.master)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Sends bits first..last of w, MSB-first, to the MSB instance on consecutive cycles.
    task automatic send_bits(input logic [7:0] w, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            bit_in = w[7-i];
            bit_en = 1'b1;
            @(negedge i2c_clk);
        end
        bit_en = 1'b0;
    endtask

    task automatic step();
        @(negedge i2c_clk);
    endtask

    initial begin
        rst_n       = 1'b0;
        bit_in      = 1'b0;
        bit_en      = 1'b0;
        frame_clr   = 1'b0;
        ovf_clr     = 1'b0;
        bit_en_l    = 1'b0;
        frame_clr_l = 1'b0;
        ovf_clr_l   = 1'b0;
        m_if.out_ready = 1'b1;
        l_if.out_ready = 1'b1;
        step();
        step();
        check("reset_valid", {31'd0, m_if.out_valid}, 32'd0);
        check("reset_data", {24'd0, m_if.out_data}, 32'h00);
        check("reset_cnt", {28'd0, bit_cnt}, 32'd0);
        check("reset_ovf", {31'd0, overflow}, 32'd0);
        rst_n = 1'b1;
        step();

        // 0xA5 MSB-first, latency boundary at bit 7 -> 8
        send_bits(8'hA5, 0, 6);
        check("a5_cnt7", {28'd0, bit_cnt}, 32'd7);
        check("a5_valid_early", {31'd0, m_if.out_valid}, 32'd0);
        send_bits(8'hA5, 7, 7);
        check("a5_valid", {31'd0, m_if.out_valid}, 32'd1);
        check("a5_data", {24'd0, m_if.out_data}, 32'hA5);
        check("a5_cnt0", {28'd0, bit_cnt}, 32'd0);
        step();
        check("a5_popped", {31'd0, m_if.out_valid}, 32'd0);

        // LSB-first order: 1,1,0,0,0,0,0,0 -> 0x03
        for (int i = 0; i < 8; i++) begin
            bit_in   = (i < 2);
            bit_en_l = 1'b1;
            step();
        end
        bit_en_l = 1'b0;
        check("lsb_valid", {31'd0, l_if.out_valid}, 32'd1);
        check("lsb_data", {24'd0, l_if.out_data}, 32'h03);
        check("lsb_msb_idle", {31'd0, m_if.out_valid}, 32'd0);
        step();

        // Partial 0xFF then frame_clr (with a bit offered), then 0x3C
        send_bits(8'hFF, 0, 4);
        check("fc_cnt5", {28'd0, bit_cnt}, 32'd5);
        frame_clr = 1'b1;
        bit_in    = 1'b1;
        bit_en    = 1'b1;
        step();
        frame_clr = 1'b0;
        bit_en    = 1'b0;
        check("fc_cnt0", {28'd0, bit_cnt}, 32'd0);
        check("fc_no_word", {31'd0, m_if.out_valid}, 32'd0);
        send_bits(8'h3C, 0, 7);
        check("fc_data", {24'd0, m_if.out_data}, 32'h3C);
        check("fc_valid", {31'd0, m_if.out_valid}, 32'd1);
        step();
        check("fc_popped", {31'd0, m_if.out_valid}, 32'd0);

        // Overflow: 0x11, 0x22, 0x33 with consumer stalled; ovf_clr coincides with the drop
        m_if.out_ready = 1'b0;
        send_bits(8'h11, 0, 7);
        send_bits(8'h22, 0, 7);
        check("ovf_none_yet", {31'd0, overflow}, 32'd0);
        send_bits(8'h33, 0, 6);
        ovf_clr = 1'b1;
        send_bits(8'h33, 7, 7);
        ovf_clr = 1'b0;
        check("ovf_set", {31'd0, overflow}, 32'd1);
        check("ovf_head_stable", {24'd0, m_if.out_data}, 32'h11);
        m_if.out_ready = 1'b1;
        step();
        check("ovf_pop2", {24'd0, m_if.out_data}, 32'h22);
        check("ovf_pop2_valid", {31'd0, m_if.out_valid}, 32'd1);
        step();
        check("ovf_no_33", {31'd0, m_if.out_valid}, 32'd0);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("ovf_cleared", {31'd0, overflow}, 32'd0);

        // Full buffer, pop coincides with completion of 0x44
        m_if.out_ready = 1'b0;
        send_bits(8'h11, 0, 7);
        send_bits(8'h22, 0, 7);
        send_bits(8'h44, 0, 6);
        check("fp_head11", {24'd0, m_if.out_data}, 32'h11);
        m_if.out_ready = 1'b1;
        send_bits(8'h44, 7, 7);
        check("fp_no_ovf", {31'd0, overflow}, 32'd0);
        check("fp_head22", {24'd0, m_if.out_data}, 32'h22);
        step();
        check("fp_head44", {24'd0, m_if.out_data}, 32'h44);
        check("fp_valid44", {31'd0, m_if.out_valid}, 32'd1);
        step();
        check("fp_empty", {31'd0, m_if.out_valid}, 32'd0);

        // Reset mid-word with two buffered words and overflow set
        m_if.out_ready = 1'b0;
        send_bits(8'h55, 0, 7);
        send_bits(8'h66, 0, 7);
        send_bits(8'h77, 0, 7);
        send_bits(8'hE0, 0, 2);
        check("rst_pre_cnt", {28'd0, bit_cnt}, 32'd3);
        check("rst_pre_ovf", {31'd0, overflow}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", {31'd0, m_if.out_valid}, 32'd0);
        check("rst_async_cnt", {28'd0, bit_cnt}, 32'd0);
        check("rst_async_ovf", {31'd0, overflow}, 32'd0);
        step();
        rst_n = 1'b1;
        m_if.out_ready = 1'b1;
        step();
        send_bits(8'h00, 0, 4);
        check("zero_early", {31'd0, m_if.out_valid}, 32'd0);
        send_bits(8'h00, 5, 7);
        check("zero_valid", {31'd0, m_if.out_valid}, 32'd1);
        check("zero_data", {24'd0, m_if.out_data}, 32'h00);
        send_bits(8'h81, 0, 7);
        check("after_zero_data", {24'd0, m_if.out_data}, 32'h81);
        check("after_zero_valid", {31'd0, m_if.out_valid}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
